io_bus_bridge: RTL and testbench

IO_BUS_BRIDGE -- requirements
Module: io_bus_bridge

---
 rtl/io_bus_bridge_if.sv | 43 ++++
 rtl/io_bus_bridge.sv | 134 +++++++++++++
 tb/tb_io_bus_bridge.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/io_bus_bridge_if.sv
`default_nettype none
// ============================================================================
// io_bus_bridge_if : core / RAM / peripheral signal bundle for io_bus_bridge
// Revision 1.0
// ============================================================================
interface io_bus_bridge_if #(
  parameter int WORD_SIZE  = 20,
  parameter int NUM_PERIPH = 4,
  parameter int REG_BITS   = 5
);
  logic [WORD_SIZE-1:0]            core_addr;
  logic [WORD_SIZE-1:0]            core_write_value;
  logic                            core_write_enable;
  logic [WORD_SIZE-1:0]            core_read_value;
  logic                            core_stall;
  logic                            ram_write_enable;
  logic [WORD_SIZE-1:0]            ram_read_value;
  logic [NUM_PERIPH-1:0]           periph_req;
  logic [REG_BITS-1:0]             periph_index;
  logic                            periph_write;
  logic [WORD_SIZE-1:0]            periph_write_value;
  logic [NUM_PERIPH*WORD_SIZE-1:0] periph_read_value;
  logic [NUM_PERIPH-1:0]           periph_ack;
  logic                            bus_error;
  logic [15:0]                     error_addr;

  // Bridge side
  modport slave (
    input  core_addr, core_write_value, core_write_enable, ram_read_value,
           periph_read_value, periph_ack,
    output core_read_value, core_stall, ram_write_enable, periph_req,
           periph_index, periph_write, periph_write_value, bus_error, error_addr
  );

  // Core, RAM and peripheral side
  modport master (
    output core_addr, core_write_value, core_write_enable, ram_read_value,
           periph_read_value, periph_ack,
    input  core_read_value, core_stall, ram_write_enable, periph_req,
           periph_index, periph_write, periph_write_value, bus_error, error_addr
  );
endinterface
`default_nettype wire

// File: rtl/io_bus_bridge.sv
`default_nettype none
// ============================================================================
// io_bus_bridge : decodes core accesses into RAM or stalling peripheral I/O
// Revision 1.0
// ============================================================================
module io_bus_bridge #(
  parameter int WORD_SIZE  = 20,
  parameter int NUM_PERIPH = 4,
  parameter int SEL_BITS   = 2,
  parameter int REG_BITS   = 5,
  parameter int TIMEOUT    = 15
) (
  input  wire         clk,
  input  wire         reset_n,
  io_bus_bridge_if.slave bus
);
  localparam int                IO_LSB         = REG_BITS + SEL_BITS;
  localparam logic [SEL_BITS:0] C_NUM_PERIPH   = (SEL_BITS+1)'(NUM_PERIPH);
  localparam logic [7:0]        C_TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [7:0]            cnt_q;
  logic [WORD_SIZE-1:0]  rdata_q;
  logic [NUM_PERIPH-1:0] req_q;
  logic [REG_BITS-1:0]   index_q;
  logic                  write_q;
  logic [WORD_SIZE-1:0]  wdata_q;
  logic                  err_q;
  logic [15:0]           err_addr_q;

  logic                  w_io;
  logic [SEL_BITS-1:0]   w_chan;
  logic                  w_chan_ok;
  logic [NUM_PERIPH-1:0] w_onehot;
  logic                  w_ack_hit;
  logic                  w_timeout;
  logic [WORD_SIZE-1:0]  w_masked [NUM_PERIPH];
  logic [WORD_SIZE-1:0]  w_sel_data;

  assign w_io      = &bus.core_addr[15:IO_LSB];
  assign w_chan    = bus.core_addr[IO_LSB-1:REG_BITS];
  assign w_chan_ok = ({1'b0, w_chan} < C_NUM_PERIPH);
  assign w_timeout = (cnt_q == C_TIMEOUT_LAST);
  // req_q is one-hot in WAIT, so masking acks with it ignores other channels
  assign w_ack_hit = |(bus.periph_ack & req_q);

  generate
    for (genvar c = 0; c < NUM_PERIPH; c++) begin : g_chan
      assign w_onehot[c] = (w_chan == SEL_BITS'(c));
      assign w_masked[c] = req_q[c] ? bus.periph_read_value[c*WORD_SIZE +: WORD_SIZE]
                                    : '0;
    end
    if (WORD_SIZE > 16) begin : g_hi_addr
      logic w_unused_hi;
      assign w_unused_hi = ^bus.core_addr[WORD_SIZE-1:16];
    end
  endgenerate

  always_comb begin
    w_sel_data = '0;
    for (int c = 0; c < NUM_PERIPH; c++) begin
      w_sel_data = w_sel_data | w_masked[c];
    end
  end

  assign bus.core_stall         = ((state_q == ST_IDLE) && w_io) || (state_q == ST_WAIT);
  assign bus.ram_write_enable   = bus.core_write_enable && !w_io && (state_q == ST_IDLE);
  assign bus.core_read_value    = (state_q == ST_DONE) ? rdata_q : bus.ram_read_value;
  assign bus.periph_req         = req_q;
  assign bus.periph_index       = index_q;
  assign bus.periph_write       = write_q;
  assign bus.periph_write_value = wdata_q;
  assign bus.bus_error          = err_q;
  assign bus.error_addr         = err_addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      req_q      <= '0;
      index_q    <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_io) begin
            if (w_chan_ok) begin
              req_q   <= w_onehot;
              index_q <= bus.core_addr[REG_BITS-1:0];
              write_q <= bus.core_write_enable;
              wdata_q <= bus.core_write_value;
              cnt_q   <= '0;
              state_q <= ST_WAIT;
            end else begin
              rdata_q <= '1;
              err_q   <= 1'b1;
              if (!err_q) err_addr_q <= bus.core_addr[15:0];
              state_q <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          // An ack arriving on the last permitted cycle still completes normally
          if (w_ack_hit) begin
            rdata_q <= w_sel_data;
            req_q   <= '0;
            state_q <= ST_DONE;
          end else if (w_timeout) begin
            rdata_q <= '1;
            req_q   <= '0;
            err_q   <= 1'b1;
            if (!err_q) err_addr_q <= bus.core_addr[15:0];
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_io_bus_bridge.sv
`default_nettype none
// ============================================================================
// tb_io_bus_bridge : directed checks of io_bus_bridge (4- and 3-channel builds)
// Revision 1.0
// ============================================================================
module tb_io_bus_bridge;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  io_bus_bridge_if #(.WORD_SIZE(20), .NUM_PERIPH(4), .REG_BITS(5)) ifa ();
  io_bus_bridge_if #(.WORD_SIZE(20), .NUM_PERIPH(3), .REG_BITS(5)) ifb ();

  io_bus_bridge #(.WORD_SIZE(20), .NUM_PERIPH(4), .SEL_BITS(2), .REG_BITS(5), .TIMEOUT(15))
    u_dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  io_bus_bridge #(.WORD_SIZE(20), .NUM_PERIPH(3), .SEL_BITS(2), .REG_BITS(5), .TIMEOUT(15))
    u_dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifa.core_addr = '0; ifa.core_write_value = '0; ifa.core_write_enable = 1'b0;
    ifa.ram_read_value = 20'h00077; ifa.periph_read_value = '0; ifa.periph_ack = '0;
    ifb.core_addr = '0; ifb.core_write_value = '0; ifb.core_write_enable = 1'b0;
    ifb.ram_read_value = '0; ifb.periph_read_value = '0; ifb.periph_ack = '0;
    reset_n = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    checks++; if (ifa.periph_req !== 4'b0000) begin errors++; $display("FAIL reset_req got %b exp 0000", ifa.periph_req); end
    checks++; if (ifa.core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", ifa.core_stall); end
    checks++; if (ifa.bus_error !== 1'b0 || ifa.error_addr !== 16'h0) begin errors++; $display("FAIL reset_err got %b/%h exp 0/0000", ifa.bus_error, ifa.error_addr); end
    checks++; if (ifa.periph_write !== 1'b0 || ifa.periph_index !== 5'd0 || ifa.periph_write_value !== 20'h0) begin
      errors++; $display("FAIL reset_periph got %b/%h/%h exp 0/00/00000", ifa.periph_write, ifa.periph_index, ifa.periph_write_value); end
    checks++; if (ifa.core_read_value !== 20'h00077) begin errors++; $display("FAIL reset_rdata got %h exp 00077", ifa.core_read_value); end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_io_read();
    ifa.core_addr = 20'h0FFA3; ifa.core_write_enable = 1'b0;
    @(negedge clk);
    checks++; if (ifa.core_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_idle got %b exp 1", ifa.core_stall); end
    cyc(); ifa.ram_read_value = 20'h11111;
    @(negedge clk);
    checks++; if (ifa.periph_req !== 4'b0010 || ifa.periph_index !== 5'd3 || ifa.periph_write !== 1'b0) begin
      errors++; $display("FAIL rd_req got %b/%0d/%b exp 0010/3/0", ifa.periph_req, ifa.periph_index, ifa.periph_write); end
    checks++; if (ifa.core_stall !== 1'b1 || ifa.core_read_value !== 20'h11111) begin
      errors++; $display("FAIL rd_wait1 got %b/%h exp 1/11111", ifa.core_stall, ifa.core_read_value); end
    cyc(); ifa.periph_ack = 4'b0010; ifa.periph_read_value[20 +: 20] = 20'h12345;
    @(negedge clk);
    checks++; if (ifa.core_stall !== 1'b1) begin errors++; $display("FAIL rd_wait2_stall got %b exp 1", ifa.core_stall); end
    cyc(); ifa.periph_ack = '0;
    @(negedge clk);
    checks++; if (ifa.core_stall !== 1'b0 || ifa.periph_req !== 4'b0000 || ifa.core_read_value !== 20'h12345) begin
      errors++; $display("FAIL rd_done got %b/%b/%h exp 0/0000/12345", ifa.core_stall, ifa.periph_req, ifa.core_read_value); end
    ifa.core_addr = '0;
    cyc();
  endtask

  task automatic test_io_write();
    ifa.core_addr = 20'h0FF85; ifa.core_write_enable = 1'b1; ifa.core_write_value = 20'h00ABC;
    @(negedge clk);
    checks++; if (ifa.ram_write_enable !== 1'b0 || ifa.core_stall !== 1'b1) begin
      errors++; $display("FAIL wr_idle got we=%b stall=%b exp 0/1", ifa.ram_write_enable, ifa.core_stall); end
    cyc(); ifa.periph_ack = 4'b0001;
    @(negedge clk);
    checks++; if (ifa.periph_req !== 4'b0001 || ifa.periph_write !== 1'b1 || ifa.periph_write_value !== 20'h00ABC || ifa.periph_index !== 5'd5) begin
      errors++; $display("FAIL wr_wait got %b/%b/%h/%0d exp 0001/1/00ABC/5", ifa.periph_req, ifa.periph_write, ifa.periph_write_value, ifa.periph_index); end
    checks++; if (ifa.ram_write_enable !== 1'b0) begin errors++; $display("FAIL wr_wait_ramwe got %b exp 0", ifa.ram_write_enable); end
    cyc(); ifa.periph_ack = '0;
    @(negedge clk);
    checks++; if (ifa.ram_write_enable !== 1'b0 || ifa.core_stall !== 1'b0 || ifa.periph_req !== 4'b0000) begin
      errors++; $display("FAIL wr_done got we=%b stall=%b req=%b exp 0/0/0000", ifa.ram_write_enable, ifa.core_stall, ifa.periph_req); end
    ifa.core_addr = '0; ifa.core_write_enable = 1'b0;
    cyc();
  endtask

  task automatic test_reset_in_wait();
    ifa.core_addr = 20'h0FFA3;
    cyc();
    for (int k = 1; k <= 3; k++) begin
      ifa.periph_ack = 4'b0100; ifa.periph_read_value[40 +: 20] = 20'h0DEAD;
      @(negedge clk);
      checks++; if (ifa.periph_req !== 4'b0010 || ifa.core_stall !== 1'b1) begin
        errors++; $display("FAIL other_ack_%0d got req=%b stall=%b exp 0010/1", k, ifa.periph_req, ifa.core_stall); end
      cyc();
    end
    reset_n = 1'b0;
    #1;
    checks++; if (ifa.periph_req !== 4'b0000 || ifa.bus_error !== 1'b0) begin
      errors++; $display("FAIL rst_wait_req got req=%b err=%b exp 0000/0", ifa.periph_req, ifa.bus_error); end
    ifa.core_addr = '0; ifa.periph_ack = '0; ifa.ram_read_value = 20'h22222;
    #1;
    checks++; if (ifa.core_stall !== 1'b0) begin errors++; $display("FAIL rst_wait_stall got %b exp 0", ifa.core_stall); end
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    @(negedge clk);
    checks++; if (ifa.core_stall !== 1'b0 || ifa.core_read_value !== 20'h22222 || ifa.bus_error !== 1'b0) begin
      errors++; $display("FAIL rst_wait_after got %b/%h/%b exp 0/22222/0", ifa.core_stall, ifa.core_read_value, ifa.bus_error); end
  endtask

  task automatic test_ack_at_timeout();
    cyc(); ifa.core_addr = 20'h0FFA3;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (k == 15) begin
        ifa.periph_ack = 4'b0010; ifa.periph_read_value[20 +: 20] = 20'h0BEEF;
      end
    end
    @(negedge clk);
    checks++; if (ifa.core_stall !== 1'b1) begin errors++; $display("FAIL tmo_ack_wait15 got %b exp 1", ifa.core_stall); end
    cyc(); ifa.periph_ack = '0;
    @(negedge clk);
    checks++; if (ifa.core_stall !== 1'b0 || ifa.core_read_value !== 20'h0BEEF || ifa.bus_error !== 1'b0) begin
      errors++; $display("FAIL tmo_ack_done got %b/%h/%b exp 0/0BEEF/0", ifa.core_stall, ifa.core_read_value, ifa.bus_error); end
    ifa.core_addr = '0;
    cyc();
  endtask

  task automatic run_no_ack(input logic [19:0] addr, output int waits, output bit done);
    ifa.core_addr = addr;
    waits = 0; done = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 40 && !done; k++) begin
      cyc();
      @(negedge clk);
      if (ifa.core_stall) waits++;
      else done = 1'b1;
    end
  endtask

  task automatic test_timeout();
    int  waits;
    bit  done;
    run_no_ack(20'h0FFC0, waits, done);
    checks++; if (done !== 1'b1 || waits != 15) begin errors++; $display("FAIL tmo1_len got done=%b waits=%0d exp 1/15", done, waits); end
    checks++; if (ifa.core_read_value !== 20'hFFFFF || ifa.bus_error !== 1'b1 || ifa.error_addr !== 16'hFFC0) begin
      errors++; $display("FAIL tmo1_done got %h/%b/%h exp FFFFF/1/FFC0", ifa.core_read_value, ifa.bus_error, ifa.error_addr); end
    ifa.core_addr = '0;
    cyc();
    run_no_ack(20'h0FFC1, waits, done);
    checks++; if (done !== 1'b1 || waits != 15) begin errors++; $display("FAIL tmo2_len got done=%b waits=%0d exp 1/15", done, waits); end
    checks++; if (ifa.bus_error !== 1'b1 || ifa.error_addr !== 16'hFFC0) begin
      errors++; $display("FAIL tmo2_sticky got %b/%h exp 1/FFC0", ifa.bus_error, ifa.error_addr); end
    ifa.core_addr = '0;
    cyc();
  endtask

  task automatic test_ram();
    ifa.core_addr = 20'h00100; ifa.core_write_enable = 1'b1; ifa.core_write_value = 20'h0A5A5;
    @(negedge clk);
    checks++; if (ifa.ram_write_enable !== 1'b1 || ifa.core_stall !== 1'b0) begin
      errors++; $display("FAIL ram_wr got we=%b stall=%b exp 1/0", ifa.ram_write_enable, ifa.core_stall); end
    cyc(); ifa.core_write_enable = 1'b0; ifa.ram_read_value = 20'h5A5A5;
    @(negedge clk);
    checks++; if (ifa.ram_write_enable !== 1'b0 || ifa.core_stall !== 1'b0 || ifa.core_read_value !== 20'h5A5A5) begin
      errors++; $display("FAIL ram_rd got %b/%b/%h exp 0/0/5A5A5", ifa.ram_write_enable, ifa.core_stall, ifa.core_read_value); end
    cyc();
  endtask

  task automatic test_bad_channel();
    ifb.core_addr = 20'h0FFE0;
    @(negedge clk);
    checks++; if (ifb.core_stall !== 1'b1 || ifb.periph_req !== 3'b000) begin
      errors++; $display("FAIL oob_idle got stall=%b req=%b exp 1/000", ifb.core_stall, ifb.periph_req); end
    cyc();
    @(negedge clk);
    checks++; if (ifb.core_stall !== 1'b0 || ifb.periph_req !== 3'b000 || ifb.core_read_value !== 20'hFFFFF) begin
      errors++; $display("FAIL oob_done got %b/%b/%h exp 0/000/FFFFF", ifb.core_stall, ifb.periph_req, ifb.core_read_value); end
    checks++; if (ifb.bus_error !== 1'b1 || ifb.error_addr !== 16'hFFE0) begin
      errors++; $display("FAIL oob_err got %b/%h exp 1/FFE0", ifb.bus_error, ifb.error_addr); end
    ifb.core_addr = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_io_read();
    test_io_write();
    test_reset_in_wait();
    test_ack_at_timeout();
    test_timeout();
    test_ram();
    test_bad_channel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
